// File: rtl/text_char_fetch.sv
// Text-mode pixel front end: sync-gen coordinates -> VRAM cell read -> font-ROM read -> glyph dot.
// Three pixel-period pipeline with delay-matched blank/sync and a blinking underline cursor.
module text_char_fetch #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int VRAM_AW      = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_ce,
  input  logic [10:0]        hcount,
  input  logic [10:0]        vcount,
  input  logic               blank_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [23:0]        vram_data,
  output logic [11:0]        font_addr,
  input  logic [7:0]         font_data,
  input  logic [VRAM_AW-1:0] cursor_addr,
  input  logic               cursor_en,
  output logic [15:0]        char_color,
  output logic               font_dot,
  output logic               blank_out,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam int          FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic [10:0] H_LIM     = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM     = 11'(V_ACTIVE);
  localparam logic [6:0]  R_LIM     = 7'(ROWS);

  logic [6:0]         row;
  logic [7:0]         col;
  logic [VRAM_AW-1:0] row_w;
  logic [VRAM_AW-1:0] col_w;
  logic [VRAM_AW-1:0] cell_addr;
  logic               in_vis;

  assign row   = vcount[10:4];
  assign col   = hcount[10:3];
  assign row_w = VRAM_AW'(row);
  assign col_w = VRAM_AW'(col);

  // 80 columns is the common case: shift-add instead of a multiplier.
  generate
    if (COLS == 80) begin : g_mul80
      assign cell_addr = (row_w << 6) + (row_w << 4) + col_w;
    end else begin : g_mul
      assign cell_addr = row_w * VRAM_AW'(COLS) + col_w;
    end
  endgenerate

  assign in_vis = (hcount < H_LIM) && (vcount < V_LIM) && (row < R_LIM);

  // Stage 1 / stage 2 pipe registers
  logic [2:0]  bit1, bit2;
  logic [3:0]  grow1, grow2;
  logic        curs1, curs2;
  logic        blank1, blank2;
  logic        hs1, hs2, vs1, vs2;
  logic [15:0] col2;

  // Blink state
  logic [FW-1:0] fcnt;
  logic          blink_on;
  logic          vsync_prev;

  logic dot_raw;
  logic dot;

  assign dot_raw = font_data[3'd7 - bit2];
  // Underline cursor: invert the bottom two glyph rows of the cursor cell.
  assign dot     = dot_raw ^ (curs2 & cursor_en & blink_on & (grow2 >= 4'd14));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr  <= '0;
      curs1      <= 1'b0;
      bit1       <= '0;
      grow1      <= '0;
      blank1     <= 1'b1;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      col2       <= '0;
      font_addr  <= '0;
      bit2       <= '0;
      grow2      <= '0;
      curs2      <= 1'b0;
      blank2     <= 1'b1;
      hs2        <= 1'b1;
      vs2        <= 1'b1;
      font_dot   <= 1'b0;
      char_color <= '0;
      blank_out  <= 1'b1;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      fcnt       <= '0;
      blink_on   <= 1'b1;
      vsync_prev <= 1'b1;
    end else if (pix_ce) begin
      vram_addr <= in_vis ? cell_addr : '0;
      curs1     <= in_vis && (cell_addr == cursor_addr);
      bit1      <= hcount[2:0];
      grow1     <= vcount[3:0];
      blank1    <= blank_in;
      hs1       <= hsync_in;
      vs1       <= vsync_in;

      col2      <= vram_data[15:0];
      font_addr <= {vram_data[23:16], grow1};
      bit2      <= bit1;
      grow2     <= grow1;
      curs2     <= curs1;
      blank2    <= blank1;
      hs2       <= hs1;
      vs2       <= vs1;

      if (blank2) begin
        font_dot   <= 1'b0;
        char_color <= '0;
      end else begin
        font_dot   <= dot;
        char_color <= col2;
      end
      blank_out <= blank2;
      hsync_out <= hs2;
      vsync_out <= vs2;

      vsync_prev <= vsync_in;
      if (vsync_prev && !vsync_in) begin
        if (fcnt == FCNT_MAX) begin
          fcnt     <= '0;
          blink_on <= ~blink_on;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_char_fetch.sv
// Self-checking bench for text_char_fetch: VRAM/font models feed the DUT, a queue of
// expected pixels is compared three strobes after each pixel is driven.
module tb_text_char_fetch;

  localparam int BF = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_ce = 1'b0;
  logic [10:0] hcount = '0;
  logic [10:0] vcount = '0;
  logic        blank_in = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [11:0] vram_addr;
  logic [23:0] vram_data = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [11:0] cursor_addr = 12'hFFF;
  logic        cursor_en = 1'b0;
  logic [15:0] char_color;
  logic        font_dot;
  logic        blank_out;
  logic        hsync_out;
  logic        vsync_out;

  text_char_fetch dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount),
    .blank_in(blank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vram_addr(vram_addr), .vram_data(vram_data), .font_addr(font_addr), .font_data(font_data),
    .cursor_addr(cursor_addr), .cursor_en(cursor_en), .char_color(char_color), .font_dot(font_dot),
    .blank_out(blank_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] vram_model(input logic [11:0] a);
    if (a == 12'd162) return 24'h41_1F03;
    return {a[7:0] ^ {a[11:8], 4'h3}, a[7:0] + 8'd7, ~a[7:0]};
  endfunction

  function automatic logic [7:0] font_model(input logic [11:0] fa);
    if (fa == 12'h413) return 8'b0010_0000;
    return fa[7:0] ^ {fa[3:0], fa[11:8]} ^ 8'h6C;
  endfunction

  // Memory models with one clock of read latency; glitch corrupts data between strobes.
  logic glitch = 1'b0;
  always @(posedge clk) begin
    vram_data <= glitch ? 24'hFFFFFF : vram_model(vram_addr);
    font_data <= glitch ? 8'h5A : font_model(font_addr);
  end

  typedef struct {
    logic        blank;
    logic        hs;
    logic        vs;
    logic [15:0] color;
    logic        dot_raw;
    logic        hit;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side blink model and expected address tracking
  logic        blink_m = 1'b1;
  int          fcnt_m = 0;
  logic        vs_prev_m = 1'b1;
  logic [11:0] pend_faddr = '0;
  logic [11:0] last_va = '0, last_fa = '0;
  logic        last_dot = 1'b0, last_blank = 1'b1, last_hs = 1'b1, last_vs = 1'b1;
  logic [15:0] last_color = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t reset_rec();
    exp_t r;
    r.blank = 1'b1; r.hs = 1'b1; r.vs = 1'b1; r.color = '0; r.dot_raw = 1'b0; r.hit = 1'b0;
    return r;
  endfunction

  task automatic do_reset();
    logic [23:0] w0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst vram_addr", vram_addr, 0);
    check("rst font_addr", font_addr, 0);
    check("rst char_color", char_color, 0);
    check("rst font_dot", font_dot, 0);
    check("rst blank_out", blank_out, 1);
    check("rst hsync_out", hsync_out, 1);
    check("rst vsync_out", vsync_out, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    q.push_back(reset_rec());
    q.push_back(reset_rec());
    blink_m = 1'b1; fcnt_m = 0; vs_prev_m = 1'b1;
    w0 = vram_model(12'd0);
    pend_faddr = {w0[23:16], 4'h0};
  endtask

  // One pixel: idle clk, then a strobe clk; compares addresses and the pixel 3 strobes old.
  task automatic strobe(input logic [10:0] h, input logic [10:0] v,
                        input logic bl, input logic hs, input logic vs);
    exp_t        e;
    exp_t        o;
    logic        vis;
    logic [11:0] a;
    logic [23:0] w;
    logic [7:0]  f;
    logic        ed;
    int          idx;
    @(posedge clk);
    @(negedge clk);
    hcount = h; vcount = v; blank_in = bl; hsync_in = hs; vsync_in = vs; pix_ce = 1'b1;
    vis = (h < 11'd640) && (v < 11'd480) && ((v >> 4) < 11'd30);
    a   = vis ? 12'(int'(v >> 4) * 80 + int'(h >> 3)) : 12'd0;
    w   = vram_model(a);
    f   = font_model({w[23:16], v[3:0]});
    idx = 7 - int'(h[2:0]);
    e.blank = bl; e.hs = hs; e.vs = vs;
    e.color   = bl ? 16'h0000 : w[15:0];
    e.dot_raw = bl ? 1'b0 : f[idx];
    e.hit     = !bl && vis && (a == cursor_addr) && (v[3:0] >= 4'd14);
    q.push_back(e);
    @(posedge clk);
    #1 pix_ce = 1'b0;
    check("vram_addr", vram_addr, a);
    check("font_addr", font_addr, pend_faddr);
    last_va = a;
    last_fa = pend_faddr;
    pend_faddr = {w[23:16], v[3:0]};
    if (q.size() >= 3) begin
      o  = q.pop_front();
      ed = o.dot_raw ^ (o.hit & cursor_en & blink_m);
      check("blank_out", blank_out, o.blank);
      check("hsync_out", hsync_out, o.hs);
      check("vsync_out", vsync_out, o.vs);
      check("char_color", char_color, o.color);
      check("font_dot", font_dot, ed);
      last_dot = ed; last_color = o.color; last_blank = o.blank; last_hs = o.hs; last_vs = o.vs;
    end
    if (vs_prev_m && !vs) begin
      if (fcnt_m == BF - 1) begin
        fcnt_m  = 0;
        blink_m = !blink_m;
      end else begin
        fcnt_m++;
      end
    end
    vs_prev_m = vs;
  endtask

  task automatic flush();
    repeat (2) strobe(11'd700, 11'd100, 1'b1, 1'b1, 1'b1);
  endtask

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        bl;
    logic        hs;
    logic        vs;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{h: 11'd17,  v: 11'd35,  bl: 1'b0, hs: 1'b1, vs: 1'b1, exp_addr: 12'd162};
    vecs[1] = '{h: 11'd0,   v: 11'd0,   bl: 1'b0, hs: 1'b1, vs: 1'b1, exp_addr: 12'd0};
    vecs[2] = '{h: 11'd639, v: 11'd479, bl: 1'b0, hs: 1'b1, vs: 1'b1, exp_addr: 12'd2399};
    vecs[3] = '{h: 11'd700, v: 11'd100, bl: 1'b1, hs: 1'b0, vs: 1'b1, exp_addr: 12'd0};
    vecs[4] = '{h: 11'd100, v: 11'd480, bl: 1'b1, hs: 1'b1, vs: 1'b1, exp_addr: 12'd0};
    vecs[5] = '{h: 11'd8,   v: 11'd16,  bl: 1'b0, hs: 1'b1, vs: 1'b1, exp_addr: 12'd81};
    vecs[6] = '{h: 11'd320, v: 11'd240, bl: 1'b0, hs: 1'b1, vs: 1'b1, exp_addr: 12'd1240};
    vecs[7] = '{h: 11'd639, v: 11'd0,   bl: 1'b0, hs: 1'b0, vs: 1'b1, exp_addr: 12'd79};
    vecs[8] = '{h: 11'd0,   v: 11'd479, bl: 1'b0, hs: 1'b1, vs: 1'b0, exp_addr: 12'd2320};

    // Reset mid-line, then pipeline priming: reset values for two strobes, then inputs delayed by 3.
    do_reset();
    for (int h = 200; h < 206; h++) strobe(11'(h), 11'd40, 1'b0, 1'b1, 1'b1);
    do_reset();
    for (int h = 206; h < 214; h++) strobe(11'(h), 11'd40, 1'b0, h[0], h[1]);
    flush();
    $display("reset sequence done, checks=%0d", n_checks);

    // Table of addressing vectors.
    foreach (vecs[i]) begin
      strobe(vecs[i].h, vecs[i].v, vecs[i].bl, vecs[i].hs, vecs[i].vs);
      check("table vram_addr", vram_addr, vecs[i].exp_addr);
      $display("vec %0d h=%0d v=%0d blank=%0b vram_addr=%0d", i, vecs[i].h, vecs[i].v, vecs[i].bl, vram_addr);
    end
    flush();

    // Known cell 162: char 0x41, colour 1F03, glyph row 0010_0000 (bit7 = leftmost pixel).
    strobe(11'd17, 11'd35, 1'b0, 1'b1, 1'b1);
    check("t2 vram_addr", vram_addr, 12'd162);
    strobe(11'd18, 11'd35, 1'b0, 1'b1, 1'b1);
    check("t2 font_addr", font_addr, 12'h413);
    strobe(11'd700, 11'd35, 1'b1, 1'b1, 1'b1);
    check("t2 px17 font_dot", font_dot, 1'b0);
    check("t2 px17 char_color", char_color, 16'h1F03);
    strobe(11'd700, 11'd35, 1'b1, 1'b1, 1'b1);
    check("t2 px18 font_dot", font_dot, 1'b1);
    check("t2 px18 char_color", char_color, 16'h1F03);
    flush();
    $display("cell 162 sequence done, checks=%0d", n_checks);

    // Full visible line 0: address steps every 8 pixels, dots match the font model.
    for (int h = 0; h < 640; h++) begin
      strobe(11'(h), 11'd0, 1'b0, 1'b1, 1'b1);
      check("sweep vram_addr", vram_addr, 12'(h / 8));
    end
    strobe(11'd700, 11'd0, 1'b1, 1'b1, 1'b1);
    check("blank vram_addr", vram_addr, 12'd0);
    flush();
    check("blank font_dot", font_dot, 1'b0);
    check("blank char_color", char_color, 16'h0000);
    $display("line sweep done, checks=%0d", n_checks);

    // Cursor on cell 5: rows 14/15 inverted while blink is on, row 13 untouched.
    do_reset();
    cursor_addr = 12'd5;
    cursor_en   = 1'b1;
    for (int h = 40; h < 49; h++) strobe(11'(h), 11'd14, 1'b0, 1'b1, 1'b1);
    for (int h = 40; h < 48; h++) strobe(11'(h), 11'd13, 1'b0, 1'b1, 1'b1);
    for (int h = 40; h < 48; h++) strobe(11'(h), 11'd15, 1'b0, 1'b1, 1'b1);
    flush();
    for (int fr = 0; fr < BF; fr++) begin
      strobe(11'd700, 11'd500, 1'b1, 1'b1, 1'b0);
      strobe(11'd700, 11'd500, 1'b1, 1'b1, 1'b1);
    end
    for (int h = 40; h < 48; h++) strobe(11'(h), 11'd14, 1'b0, 1'b1, 1'b1);
    flush();
    cursor_en = 1'b0;
    $display("cursor/blink sequence done, checks=%0d", n_checks);

    // Stall: no strobes for 10 clks with garbage on the memory buses.
    for (int h = 100; h < 105; h++) strobe(11'(h), 11'd50, 1'b0, 1'b1, 1'b1);
    glitch = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("hold vram_addr", vram_addr, last_va);
      check("hold font_addr", font_addr, last_fa);
      check("hold font_dot", font_dot, last_dot);
      check("hold char_color", char_color, last_color);
      check("hold blank_out", blank_out, last_blank);
      check("hold hsync_out", hsync_out, last_hs);
      check("hold vsync_out", vsync_out, last_vs);
    end
    glitch = 1'b0;
    for (int h = 105; h < 112; h++) strobe(11'(h), 11'd50, 1'b0, 1'b1, 1'b1);
    flush();
    $display("stall sequence done, checks=%0d", n_checks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
